// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory emulator: FSM state encoding,
// recognised command opcodes and chip-select decode helper.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD,
    WR,
    IGNORE,
    ERR
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Index of the asserted bit; callers guarantee exactly one bit is set.
  function automatic logic [1:0] onehot_idx(input logic [3:0] onehot);
    onehot_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (onehot[i]) onehot_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/spi_mem_bank.sv
// One channel's byte store: a single synchronous write port and an
// asynchronous read port so the FSM can preload its shift register in the same edge.
module spi_mem_bank
  import spi_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int PTR_W     = 8
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem [MEM_BYTES];

  // NOTE: the array is deliberately not reset -- contents are preloaded from outside and must survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/spi_mem_model.sv
// Multi-channel SPI (mode 0) memory emulator: READ 0x03 / WRITE 0x02 with an
// ADDR_BITS address, one byte bank per chip select, sticky protocol error flag.
module spi_mem_model
  import spi_mem_pkg::*;
#(
  parameter int                NUM_CS    = 2,
  parameter int                MEM_BYTES = 256,
  parameter int                ADDR_BITS = 24,
  parameter logic [NUM_CS-1:0] WR_MASK   = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic [NUM_CS-1:0] spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  output logic              err_cmd,
  input  logic              err_clr
);

  localparam int PTR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CH_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CNT_W = $clog2((ADDR_BITS > 8) ? ADDR_BITS : 8);

  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_BITS - 1);

  state_e            state_q;
  logic              sclk_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [6:0]        cmd_q;
  logic [PTR_W-2:0]  addr_q;
  logic              is_rd_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [7:0]        sh_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic              busy_q;
  logic              err_q;

  logic              rise;
  logic              fall;
  logic [NUM_CS-1:0] cs_low;
  logic [NUM_CS-1:0] sel_mask;
  logic              any_low;
  logic              multi_low;
  logic              sel_release;
  logic              intrude;
  logic              active;
  logic              hold;
  logic [7:0]        cmd_next;
  logic [PTR_W-1:0]  addr_next;
  logic              cmd_done;
  logic              cmd_is_rd;
  logic              cmd_is_wr;
  logic              err_set;
  logic              wr_fire;
  logic [7:0]        wr_data;
  logic [PTR_W-1:0]  rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        bank_rdata [NUM_CS];

  assign rise      = spi_sclk & ~sclk_q;
  assign fall      = ~spi_sclk & sclk_q;
  assign cs_low    = ~spi_cs_n;
  assign any_low   = |cs_low;
  assign multi_low = |(cs_low & (cs_low - 1'b1));
  assign sel_mask  = NUM_CS'(1) << ch_q;

  // Release of our own select (or of all selects) outranks every other event,
  // including a rise in the same cycle, so a bit racing CS high is dropped.
  assign sel_release = spi_cs_n[ch_q] | ~any_low;
  assign intrude     = |(cs_low & ~sel_mask);
  assign active      = (state_q != IDLE) && (state_q != ERR);
  assign hold        = active && !sel_release && !intrude;

  assign cmd_next  = {cmd_q, spi_mosi};
  assign addr_next = {addr_q, spi_mosi};
  assign cmd_done  = hold && (state_q == CMD) && rise && (bit_cnt_q == LAST_BYTE_BIT);
  assign cmd_is_rd = (cmd_next == CMD_READ);
  assign cmd_is_wr = (cmd_next == CMD_WRITE) && WR_MASK[ch_q];

  assign err_set = ((state_q == IDLE) && multi_low)
                || (active && !sel_release && intrude)
                || (cmd_done && !cmd_is_rd && !cmd_is_wr);

  assign wr_fire = hold && (state_q == WR) && rise && (bit_cnt_q == LAST_BYTE_BIT);
  assign wr_data = {sh_q[6:0], spi_mosi};

  // Read port looks ahead: the addressed byte while the address completes,
  // otherwise the byte after ptr for the reload at a byte boundary.
  assign rd_addr = (state_q == ADDR) ? addr_next : ptr_q + 1'b1;
  assign rd_data = bank_rdata[ch_q];

  for (genvar i = 0; i < NUM_CS; i++) begin : g_bank
    spi_mem_bank #(
      .MEM_BYTES (MEM_BYTES),
      .PTR_W     (PTR_W)
    ) u_bank (
      .clk       (clk),
      .wr_en_i   (wr_fire && (ch_q == CH_W'(i))),
      .wr_addr_i (ptr_q),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (bank_rdata[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      ch_q      <= '0;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      ptr_q     <= '0;
      sh_q      <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_q <= spi_sclk;
      err_q  <= err_set | (err_q & ~err_clr);

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (multi_low) begin
            state_q <= ERR;
            busy_q  <= 1'b1;
          end else if (any_low) begin
            state_q <= CMD;
            busy_q  <= 1'b1;
            ch_q    <= CH_W'(onehot_idx(4'(cs_low)));
          end
        end

        ERR: begin
          if (!any_low) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          if (sel_release) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            bit_cnt_q <= '0;
          end else if (intrude) begin
            state_q   <= ERR;
            miso_oe_q <= 1'b0;
            bit_cnt_q <= '0;
          end else begin
            case (state_q)
              CMD: if (rise) begin
                cmd_q     <= cmd_next[6:0];
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BYTE_BIT) begin
                  bit_cnt_q <= '0;
                  is_rd_q   <= cmd_is_rd;
                  state_q   <= (cmd_is_rd || cmd_is_wr) ? ADDR : IGNORE;
                end
              end

              ADDR: if (rise) begin
                addr_q    <= addr_next[PTR_W-2:0];
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_ADDR_BIT) begin
                  bit_cnt_q <= '0;
                  ptr_q     <= addr_next;
                  if (is_rd_q) begin
                    state_q   <= RD;
                    sh_q      <= rd_data;
                    miso_oe_q <= 1'b1;
                  end else begin
                    state_q <= WR;
                  end
                end
              end

              RD: if (fall) begin
                miso_q    <= sh_q[7];
                sh_q      <= {sh_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BYTE_BIT) begin
                  bit_cnt_q <= '0;
                  ptr_q     <= ptr_q + 1'b1;
                  sh_q      <= rd_data;
                end
              end

              WR: if (rise) begin
                sh_q      <= wr_data;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BYTE_BIT) begin
                  bit_cnt_q <= '0;
                  ptr_q     <= ptr_q + 1'b1;
                end
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign busy        = busy_q;
  assign err_cmd     = err_q;

endmodule

// File: tb/tb_spi_mem_model.sv
// Directed bench for spi_mem_model: a bit-level SPI master with a byte-array
// reference model; every clk the four outputs are compared with model expectations.
module tb_spi_mem_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk;
  logic [1:0] spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       busy;
  logic       err_cmd;
  logic       err_clr;

  always #5 clk = ~clk;

  spi_mem_model #(
    .NUM_CS    (2),
    .MEM_BYTES (256),
    .ADDR_BITS (24),
    .WR_MASK   (2'b10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .err_cmd     (err_cmd),
    .err_clr     (err_clr)
  );

  int total = 0;
  int bad   = 0;

  logic       exp_miso, exp_oe, exp_busy, exp_err;
  bit         cmp_en;
  logic [7:0] model_mem [2][256];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled 1ns after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      check("cyc_miso", spi_miso, exp_miso);
      check("cyc_miso_oe", spi_miso_oe, exp_oe);
      check("cyc_busy", busy, exp_busy);
      check("cyc_err_cmd", err_cmd, exp_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int ch, input int a, input logic [7:0] v);
    model_mem[ch][a] = v;
    if (ch == 0) dut.g_bank[0].u_bank.mem[a] = v;
    else         dut.g_bank[1].u_bank.mem[a] = v;
  endtask

  function automatic logic [7:0] peek(input int ch, input int a);
    if (ch == 0) return dut.g_bank[0].u_bank.mem[a];
    return dut.g_bank[1].u_bank.mem[a];
  endfunction

  // Bit k of the read data stream starting at byte address base.
  function automatic logic model_bit(input int ch, input int base, input int k);
    logic [7:0] v;
    v = model_mem[ch][(base + k / 8) % 256];
    return v[7 - (k % 8)];
  endfunction

  // One CPU-style transaction: CS low, cmd + 24-bit address + ndata bits, trailing
  // fall, CS high. sclk phases are 3 clk each. rst_at >= 0 pulses rst_n at that bit.
  task automatic frame(input int ch, input logic [7:0] cmd, input int addr,
                       input int ndata, input int rst_at);
    int          nbits = 32 + ndata;
    bit          ok_rd = (cmd == 8'h03);
    bit          ok_wr = (cmd == 8'h02) && (ch == 1);
    logic [31:0] hdr   = {cmd, addr[23:0]};
    int          base  = addr % 256;
    @(negedge clk);
    spi_cs_n[ch] = 1'b0;
    exp_busy     = 1'b1;
    wait_clk(3);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_at) begin
        rst_n    = 1'b0;
        spi_cs_n = 2'b11;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        exp_miso = 1'b0;
        exp_oe   = 1'b0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        #1;
        check("rst_async_oe", spi_miso_oe, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_miso", spi_miso, 1'b0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        return;
      end
      spi_sclk = 1'b0;
      spi_mosi = (b < 32) ? hdr[31 - b] : wbuf[(b - 32) / 8][7 - ((b - 32) % 8)];
      if (ok_rd && b >= 32) exp_miso = model_bit(ch, base, b - 32);
      wait_clk(3);
      spi_sclk = 1'b1;
      if (b == 7 && !ok_rd && !ok_wr) exp_err = 1'b1;
      if (b == 31 && ok_rd) exp_oe = 1'b1;
      if (ok_rd && b >= 32) rbuf[(b - 32) / 8][7 - ((b - 32) % 8)] = spi_miso;
      if (ok_wr && b >= 32 && ((b - 32) % 8) == 7)
        model_mem[ch][(base + (b - 32) / 8) % 256] = wbuf[(b - 32) / 8];
      wait_clk(3);
    end
    spi_sclk = 1'b0;
    if (ok_rd) exp_miso = model_bit(ch, base, nbits - 32);
    wait_clk(3);
    spi_cs_n = 2'b11;
    exp_busy = 1'b0;
    exp_oe   = 1'b0;
    wait_clk(3);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_cs_n = 2'b11;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    err_clr  = 1'b0;
    exp_miso = 1'b0;
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    exp_err  = 1'b0;
    cmp_en   = 1'b0;
    for (int a = 0; a < 256; a++) begin
      poke(0, a, 8'(a * 7 + 1));
      poke(1, a, ~8'(a));
    end
    poke(0, 8'h10, 8'hDE);
    poke(0, 8'h11, 8'hAD);
    poke(0, 8'h12, 8'hBE);
    poke(0, 8'h13, 8'hEF);
    poke(0, 8'hFF, 8'h5A);
    poke(0, 8'h00, 8'hC3);
    poke(0, 8'h05, 8'h77);

    wait_clk(3);
    check("reset_busy", busy, 1'b0);
    check("reset_oe", spi_miso_oe, 1'b0);
    check("reset_err", err_cmd, 1'b0);
    check("reset_miso", spi_miso, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    wait_clk(2);

    // 1. plain read of four bytes on ch0
    frame(0, 8'h03, 24'h000010, 32, -1);
    check("rd_b0", rbuf[0], 8'hDE);
    check("rd_b1", rbuf[1], 8'hAD);
    check("rd_b2", rbuf[2], 8'hBE);
    check("rd_b3", rbuf[3], 8'hEF);

    // 2. write on ch1 then read it back
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    frame(1, 8'h02, 24'h000020, 16, -1);
    check("wr_mem20", peek(1, 8'h20), 8'h11);
    check("wr_mem21", peek(1, 8'h21), 8'h22);
    frame(1, 8'h03, 24'h000020, 16, -1);
    check("wr_rb0", rbuf[0], 8'h11);
    check("wr_rb1", rbuf[1], 8'h22);

    // 3. write to read-only ch0, error clear, unknown opcode
    wbuf[0] = 8'h55;
    frame(0, 8'h02, 24'h000040, 8, -1);
    check("ro_err", err_cmd, 1'b1);
    check("ro_unchanged", peek(0, 8'h40), 8'hC1);
    clear_err();
    @(negedge clk);
    check("err_cleared", err_cmd, 1'b0);
    frame(0, 8'h9F, 24'h000000, 0, -1);
    check("badcmd_err", err_cmd, 1'b1);
    clear_err();

    // 4. wrap at the top of the array and address modulo MEM_BYTES
    frame(0, 8'h03, 24'h0000FF, 16, -1);
    check("wrap_b0", rbuf[0], 8'h5A);
    check("wrap_b1", rbuf[1], 8'hC3);
    frame(0, 8'h03, 24'h000105, 8, -1);
    check("mod_addr", rbuf[0], 8'h77);

    // 5. partial byte dropped on CS release
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hF0;
    frame(1, 8'h02, 24'h000030, 12, -1);
    check("abort_full", peek(1, 8'h30), 8'hAA);
    check("abort_partial", peek(1, 8'h31), 8'hCE);

    // 6a. both selects low at once
    @(negedge clk);
    spi_cs_n = 2'b00;
    exp_busy = 1'b1;
    exp_err  = 1'b1;
    wait_clk(3);
    spi_sclk = 1'b1;
    wait_clk(3);
    spi_sclk = 1'b0;
    wait_clk(3);
    check("multi_cs_oe", spi_miso_oe, 1'b0);
    check("multi_cs_err", err_cmd, 1'b1);
    spi_cs_n = 2'b11;
    exp_busy = 1'b0;
    wait_clk(3);
    clear_err();

    // 6b. reset in the middle of a read data phase, then a clean read
    frame(0, 8'h03, 24'h000010, 32, 36);
    frame(0, 8'h03, 24'h000010, 16, -1);
    check("post_rst_b0", rbuf[0], 8'hDE);
    check("post_rst_b1", rbuf[1], 8'hAD);

    wait_clk(2);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
